chain_code_packetizer: RTL

//  Frames the encoder's chain-code byte stream into a self-describing packet for TX_UART.

---
 rtl/chain_code_packetizer_pkg.sv | 51 +++++
 rtl/chain_code_packetizer_sync_fifo.sv | 72 +++++++
 rtl/chain_code_packetizer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/chain_code_packetizer_pkg.sv
// Shared definitions for the chain-code packet format: sync byte, header layout
// and FSM states. The decoder side reuses the header index constants.
package chain_code_packetizer_pkg;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam int         HDR_LEN       = 9;

  localparam logic [3:0] HDR_SYNC     = 4'd0;
  localparam logic [3:0] HDR_START_X  = 4'd1;
  localparam logic [3:0] HDR_START_Y  = 4'd2;
  localparam logic [3:0] HDR_PERIM_HI = 4'd3;
  localparam logic [3:0] HDR_PERIM_LO = 4'd4;
  localparam logic [3:0] HDR_AREA_HI  = 4'd5;
  localparam logic [3:0] HDR_AREA_LO  = 4'd6;
  localparam logic [3:0] HDR_COUNT_HI = 4'd7;
  localparam logic [3:0] HDR_COUNT_LO = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_HDR,
    ST_PAYLOAD,
    ST_CKSUM
  } pkt_state_t;

  // Header byte selected by index; byte 1 carries the overflow flag in bit 7.
  function automatic logic [7:0] hdr_byte(
    input logic [3:0]  idx,
    input logic [7:0]  sync,
    input logic        overflow,
    input logic [5:0]  start_x,
    input logic [5:0]  start_y,
    input logic [8:0]  perimeter,
    input logic [11:0] area,
    input logic [9:0]  count
  );
    case (idx)
      HDR_SYNC:     return sync;
      HDR_START_X:  return {overflow, 1'b0, start_x};
      HDR_START_Y:  return {2'b00, start_y};
      HDR_PERIM_HI: return {7'b0, perimeter[8]};
      HDR_PERIM_LO: return perimeter[7:0];
      HDR_AREA_HI:  return {4'b0, area[11:8]};
      HDR_AREA_LO:  return area[7:0];
      HDR_COUNT_HI: return {6'b0, count[9:8]};
      HDR_COUNT_LO: return count[7:0];
      default:      return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/chain_code_packetizer_sync_fifo.sv
// Single-clock FIFO with show-ahead read data. The storage array is read through
// a register; a one-entry bypass covers a write landing on the next head address.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 512
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    rd_addr;
  logic [CW-1:0]    used_reg;
  logic [WIDTH-1:0] ram_q_reg;
  logic [WIDTH-1:0] byp_data_reg;
  logic             byp_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (used_reg == '0);
  assign full    = (used_reg == CW'(DEPTH));
  assign pop_ok  = pop && !empty && !flush;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push && !flush && (!full || pop_ok);
  assign rd_data = byp_reg ? byp_data_reg : ram_q_reg;

  always_comb begin
    rd_addr = rd_ptr_reg;
    if (reset || flush) begin
      rd_addr = '0;
    end else if (pop_ok) begin
      rd_addr = rd_ptr_reg + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
    ram_q_reg    <= mem[rd_addr];
    byp_data_reg <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      used_reg   <= '0;
      byp_reg    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      rd_ptr_reg <= rd_addr;
      used_reg   <= used_reg + CW'(push_ok) - CW'(pop_ok);
      byp_reg    <= push_ok && (wr_ptr_reg == rd_addr);
    end
  end

endmodule

// File: rtl/chain_code_packetizer.sv
// Buffers one contour's chain codes, then streams header, codes and an XOR
// checksum to the UART through a registered valid/ready output.
module chain_code_packetizer
  import chain_code_packetizer_pkg::*;
#(
  parameter int         DEPTH     = 512,
  parameter int         CNT_W     = 10,
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        code_valid,
  input  logic [7:0]  code_in,
  input  logic        frame_end,
  input  logic [5:0]  start_x,
  input  logic [5:0]  start_y,
  input  logic [8:0]  perimeter,
  input  logic [11:0] area,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        drop_err
);

  pkt_state_t       state_reg, state_next;
  logic [3:0]       hdr_idx_reg, hdr_idx_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [CNT_W-1:0] rem_reg, rem_next;
  logic             overflow_reg, overflow_next;
  logic [7:0]       csum_reg, csum_next;
  logic [7:0]       tx_data_reg, tx_data_next;
  logic             tx_valid_reg, tx_valid_next;
  logic             tx_sync_reg, tx_sync_next;
  logic             cksum_loaded_reg, cksum_loaded_next;
  logic             drop_err_reg, drop_err_next;
  logic [5:0]       start_x_reg, start_x_next;
  logic [5:0]       start_y_reg, start_y_next;
  logic [8:0]       perimeter_reg, perimeter_next;
  logic [11:0]      area_reg, area_next;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_flush;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_rd_data;

  logic             slot_free;
  logic             accept;
  logic [7:0]       csum_acc;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (fifo_flush),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (code_in),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign tx_data  = tx_data_reg;
  assign tx_valid = tx_valid_reg;
  assign drop_err = drop_err_reg;
  assign busy     = (state_reg != ST_IDLE);

  // The output register may be reloaded whenever it is empty or being drained.
  assign accept    = tx_valid_reg && tx_ready;
  assign slot_free = !tx_valid_reg || tx_ready;
  assign csum_acc  = csum_reg ^ ((accept && !tx_sync_reg) ? tx_data_reg : 8'h00);

  always_comb begin
    state_next        = state_reg;
    hdr_idx_next      = hdr_idx_reg;
    count_next        = count_reg;
    rem_next          = rem_reg;
    overflow_next     = overflow_reg;
    csum_next         = csum_reg;
    tx_data_next      = tx_data_reg;
    tx_valid_next     = tx_valid_reg;
    tx_sync_next      = tx_sync_reg;
    cksum_loaded_next = cksum_loaded_reg;
    start_x_next      = start_x_reg;
    start_y_next      = start_y_reg;
    perimeter_next    = perimeter_reg;
    area_next         = area_reg;
    drop_err_next     = 1'b0;
    fifo_push         = 1'b0;
    fifo_pop          = 1'b0;
    fifo_flush        = 1'b0;

    if (accept) begin
      tx_valid_next = 1'b0;
      csum_next     = csum_acc;
    end

    case (state_reg)
      ST_IDLE: begin
        drop_err_next = code_valid;
        if (frame_start) begin
          fifo_flush    = 1'b1;
          count_next    = '0;
          overflow_next = 1'b0;
          state_next    = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        if (frame_start) begin
          fifo_flush    = 1'b1;
          count_next    = '0;
          overflow_next = 1'b0;
          drop_err_next = code_valid;
        end else begin
          if (code_valid) begin
            if (!fifo_full) begin
              fifo_push  = 1'b1;
              count_next = count_reg + CNT_W'(1);
            end else begin
              overflow_next = 1'b1;
              drop_err_next = 1'b1;
            end
          end
          if (frame_end) begin
            start_x_next   = start_x;
            start_y_next   = start_y;
            perimeter_next = perimeter;
            area_next      = area;
            hdr_idx_next   = '0;
            csum_next      = 8'h00;
            state_next     = ST_HDR;
          end
        end
      end

      ST_HDR: begin
        drop_err_next = code_valid;
        if (slot_free) begin
          tx_valid_next = 1'b1;
          tx_data_next  = hdr_byte(hdr_idx_reg, SYNC_BYTE, overflow_reg, start_x_reg,
                                   start_y_reg, perimeter_reg, area_reg, 10'(count_reg));
          tx_sync_next  = (hdr_idx_reg == HDR_SYNC);
          hdr_idx_next  = hdr_idx_reg + 4'd1;
          if (hdr_idx_reg == 4'(HDR_LEN - 1)) begin
            rem_next          = count_reg;
            cksum_loaded_next = 1'b0;
            state_next        = (count_reg != '0) ? ST_PAYLOAD : ST_CKSUM;
          end
        end
      end

      ST_PAYLOAD: begin
        drop_err_next = code_valid;
        if (slot_free && !fifo_empty) begin
          tx_valid_next = 1'b1;
          tx_data_next  = fifo_rd_data;
          tx_sync_next  = 1'b0;
          fifo_pop      = 1'b1;
          rem_next      = rem_reg - CNT_W'(1);
          if (rem_reg == CNT_W'(1)) begin
            cksum_loaded_next = 1'b0;
            state_next        = ST_CKSUM;
          end
        end
      end

      ST_CKSUM: begin
        drop_err_next = code_valid;
        if (!cksum_loaded_reg) begin
          // csum_acc already folds in the last payload byte if it leaves this cycle.
          if (slot_free) begin
            tx_valid_next     = 1'b1;
            tx_data_next      = csum_acc;
            tx_sync_next      = 1'b0;
            cksum_loaded_next = 1'b1;
          end
        end else if (accept) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      hdr_idx_reg      <= '0;
      count_reg        <= '0;
      rem_reg          <= '0;
      overflow_reg     <= 1'b0;
      csum_reg         <= 8'h00;
      tx_data_reg      <= 8'h00;
      tx_valid_reg     <= 1'b0;
      tx_sync_reg      <= 1'b0;
      cksum_loaded_reg <= 1'b0;
      drop_err_reg     <= 1'b0;
      start_x_reg      <= '0;
      start_y_reg      <= '0;
      perimeter_reg    <= '0;
      area_reg         <= '0;
    end else begin
      state_reg        <= state_next;
      hdr_idx_reg      <= hdr_idx_next;
      count_reg        <= count_next;
      rem_reg          <= rem_next;
      overflow_reg     <= overflow_next;
      csum_reg         <= csum_next;
      tx_data_reg      <= tx_data_next;
      tx_valid_reg     <= tx_valid_next;
      tx_sync_reg      <= tx_sync_next;
      cksum_loaded_reg <= cksum_loaded_next;
      drop_err_reg     <= drop_err_next;
      start_x_reg      <= start_x_next;
      start_y_reg      <= start_y_next;
      perimeter_reg    <= perimeter_next;
      area_reg         <= area_next;
    end
  end

endmodule
